// File: rtl/img_median_stream.sv
// img_median_stream
// Loads an IMG_DIM x IMG_DIM image, PIX_PER_CYC pixels per beat, into a
// register file. It then streams out a 3x3 clamp-replicate median image, or a
// pass-through copy, in raster order over a valid/ready handshake.
// Optional build macro: MED_BORDER_PASS_EN. When it is defined, border pixels
// bypass the median and output the stored pixel.
module img_median_stream #(
  parameter int IMG_DIM     = 20,
  parameter int BIT_LENGTH  = 5,
  parameter int PIX_PER_CYC = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PIX_PER_CYC*BIT_LENGTH-1:0] pixel_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BIT_LENGTH-1:0]             pixel_out,
  output logic [$clog2(IMG_DIM)-1:0]        out_row,
  output logic [$clog2(IMG_DIM)-1:0]        out_col,
  output logic                              frame_done
);

  localparam int NPIX = IMG_DIM * IMG_DIM;
  localparam int CW   = $clog2(IMG_DIM);
  localparam int AW   = $clog2(NPIX);
  localparam int IW   = $clog2(NPIX + PIX_PER_CYC);

  localparam logic [CW-1:0] LAST_C = CW'(IMG_DIM - 1);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [IW-1:0] NPIX_I = IW'(NPIX);
  localparam logic [IW-1:0] STEP_I = IW'(PIX_PER_CYC);
  localparam logic [AW-1:0] DIM_A  = AW'(IMG_DIM);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FILTER = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Compare-exchange: returns {min, max}
  function automatic logic [2*BIT_LENGTH-1:0] cmp_swap(
    input logic [BIT_LENGTH-1:0] a,
    input logic [BIT_LENGTH-1:0] b
  );
    return (a > b) ? {b, a} : {a, b};
  endfunction

  // 19-exchange median-of-9 network; the median settles in element 4
  function automatic logic [BIT_LENGTH-1:0] median9(
    input logic [8:0][BIT_LENGTH-1:0] w
  );
    logic [8:0][BIT_LENGTH-1:0] p;
    p = w;
    {p[1], p[2]} = cmp_swap(p[1], p[2]);
    {p[4], p[5]} = cmp_swap(p[4], p[5]);
    {p[7], p[8]} = cmp_swap(p[7], p[8]);
    {p[0], p[1]} = cmp_swap(p[0], p[1]);
    {p[3], p[4]} = cmp_swap(p[3], p[4]);
    {p[6], p[7]} = cmp_swap(p[6], p[7]);
    {p[1], p[2]} = cmp_swap(p[1], p[2]);
    {p[4], p[5]} = cmp_swap(p[4], p[5]);
    {p[7], p[8]} = cmp_swap(p[7], p[8]);
    {p[0], p[3]} = cmp_swap(p[0], p[3]);
    {p[5], p[8]} = cmp_swap(p[5], p[8]);
    {p[4], p[7]} = cmp_swap(p[4], p[7]);
    {p[3], p[6]} = cmp_swap(p[3], p[6]);
    {p[1], p[4]} = cmp_swap(p[1], p[4]);
    {p[2], p[5]} = cmp_swap(p[2], p[5]);
    {p[4], p[7]} = cmp_swap(p[4], p[7]);
    {p[4], p[2]} = cmp_swap(p[4], p[2]);
    {p[6], p[4]} = cmp_swap(p[6], p[4]);
    {p[4], p[2]} = cmp_swap(p[4], p[2]);
    return p[4];
  endfunction

  state_t                  state_r;
  logic [IW-1:0]           load_idx_r;
  logic                    mode_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [BIT_LENGTH-1:0]   pixel_out_r;
  logic [CW-1:0]           out_row_r;
  logic [CW-1:0]           out_col_r;
  logic                    frame_done_r;
  logic [CW-1:0]           cur_row_r;
  logic [CW-1:0]           cur_col_r;
  logic [BIT_LENGTH-1:0]   img_r [NPIX];

  logic                    accept_s;
  logic [IW-1:0]           load_next_s;
  logic                    last_beat_s;
  logic                    cur_last_s;
  logic                    out_last_s;
  logic                    present_s;
  logic                    border_s;
  logic [CW-1:0]           row_sel_s [3];
  logic [CW-1:0]           col_sel_s [3];
  logic [AW-1:0]           win_addr_s [9];
  logic [8:0][BIT_LENGTH-1:0] win_s;
  logic [BIT_LENGTH-1:0]   res_s;

  assign accept_s    = in_valid && in_ready_r;
  assign load_next_s = load_idx_r + STEP_I;
  assign last_beat_s = (load_next_s >= NPIX_I);
  assign cur_last_s  = (cur_row_r == LAST_C) && (cur_col_r == LAST_C);
  assign out_last_s  = (out_row_r == LAST_C) && (out_col_r == LAST_C);
  assign present_s   = (state_r == ST_FILTER) &&
                       (!out_valid_r || (out_ready && !out_last_s));

  // Store accepted lanes; lanes past the end of the image are dropped
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int k = 0; k < PIX_PER_CYC; k++) begin
        if ((load_idx_r + IW'(k)) < NPIX_I) begin
          img_r[AW'(load_idx_r + IW'(k))] <= pixel_in[k*BIT_LENGTH +: BIT_LENGTH];
        end
      end
    end
  end

  // Build clamped 3x3 neighbourhood addresses around the cursor
  always_comb begin
    row_sel_s[0] = (cur_row_r == ZERO_C) ? cur_row_r : cur_row_r - CW'(1);
    row_sel_s[1] = cur_row_r;
    row_sel_s[2] = (cur_row_r == LAST_C) ? cur_row_r : cur_row_r + CW'(1);
    col_sel_s[0] = (cur_col_r == ZERO_C) ? cur_col_r : cur_col_r - CW'(1);
    col_sel_s[1] = cur_col_r;
    col_sel_s[2] = (cur_col_r == LAST_C) ? cur_col_r : cur_col_r + CW'(1);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_addr_s[i*3+j] = AW'(row_sel_s[i]) * DIM_A + AW'(col_sel_s[j]);
      end
    end
  end

  // Fetch the nine window pixels from the register file
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_s[i] = img_r[win_addr_s[i]];
    end
  end

  // Select median or stored centre pixel for the cursor position
  always_comb begin
`ifdef MED_BORDER_PASS_EN
    border_s = (cur_row_r == ZERO_C) || (cur_row_r == LAST_C) ||
               (cur_col_r == ZERO_C) || (cur_col_r == LAST_C);
`else
    border_s = 1'b0;
`endif
    if (mode_r || border_s) begin
      res_s = win_s[4];
    end else begin
      res_s = median9(win_s);
    end
  end

  // Frame sequencer: load, stream filtered pixels, pulse done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_LOAD;
      load_idx_r   <= {IW{1'b0}};
      mode_r       <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      pixel_out_r  <= {BIT_LENGTH{1'b0}};
      out_row_r    <= ZERO_C;
      out_col_r    <= ZERO_C;
      frame_done_r <= 1'b0;
      cur_row_r    <= ZERO_C;
      cur_col_r    <= ZERO_C;
    end else begin
      case (state_r)
        ST_LOAD: begin
          frame_done_r <= 1'b0;
          if (accept_s) begin
            if (load_idx_r == {IW{1'b0}}) begin
              mode_r <= mode;
            end
            if (last_beat_s) begin
              state_r    <= ST_FILTER;
              in_ready_r <= 1'b0;
              load_idx_r <= {IW{1'b0}};
              cur_row_r  <= ZERO_C;
              cur_col_r  <= ZERO_C;
            end else begin
              load_idx_r <= load_next_s;
            end
          end
        end
        ST_FILTER: begin
          if (out_valid_r && out_ready && out_last_s) begin
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b1;
            state_r      <= ST_DONE;
          end else if (present_s) begin
            pixel_out_r <= res_s;
            out_row_r   <= cur_row_r;
            out_col_r   <= cur_col_r;
            out_valid_r <= 1'b1;
            if (cur_col_r == LAST_C) begin
              cur_col_r <= ZERO_C;
              cur_row_r <= cur_last_s ? ZERO_C : cur_row_r + CW'(1);
            end else begin
              cur_col_r <= cur_col_r + CW'(1);
            end
          end
        end
        ST_DONE: begin
          frame_done_r <= 1'b0;
          in_ready_r   <= 1'b1;
          load_idx_r   <= {IW{1'b0}};
          state_r      <= ST_LOAD;
        end
        default: begin
          state_r      <= ST_LOAD;
          load_idx_r   <= {IW{1'b0}};
          in_ready_r   <= 1'b1;
          out_valid_r  <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign pixel_out  = pixel_out_r;
  assign out_row    = out_row_r;
  assign out_col    = out_col_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_img_median_stream.sv
// Scoreboard bench for img_median_stream at default parameters (20x20, 3 lanes).
// The driver loads frames and pushes the reference image into a queue. A
// separate monitor pops one expected pixel for every accepted output.
module tb_img_median_stream;

  localparam int D     = 20;
  localparam int BL    = 5;
  localparam int P     = 3;
  localparam int PW    = P * BL;
  localparam int NPIX  = D * D;
  localparam int CW    = $clog2(D);
  localparam int BEATS = (NPIX + P - 1) / P;

  logic          clk;
  logic          reset_n;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] pixel_in;
  logic          out_valid;
  logic          out_ready;
  logic [BL-1:0] pixel_out;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          frame_done;

  img_median_stream #(.IMG_DIM(D), .BIT_LENGTH(BL), .PIX_PER_CYC(P)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixel_in   (pixel_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pixel_out  (pixel_out),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [BL-1:0] pix;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } exp_t;

  exp_t          exp_q[$];
  logic [BL-1:0] img [NPIX];
  int            errors = 0;
  int            checks = 0;
  int            rdy_mode = 0;
  int            out_total = 0;
  int            done_total = 0;
  int            last_row = 0;
  int            last_col = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > D - 1) return D - 1;
    return v;
  endfunction

  // Reference: median = the value with at most 4 smaller and at least 5 not larger
  function automatic logic [BL-1:0] ref_pix(input int r, input int c, input logic m);
    logic [BL-1:0] vals [9];
    int n;
    if (m) return img[r*D + c];
`ifdef MED_BORDER_PASS_EN
    if (r == 0 || c == 0 || r == D - 1 || c == D - 1) return img[r*D + c];
`endif
    n = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        vals[n] = img[clampi(r + dr)*D + clampi(c + dc)];
        n++;
      end
    end
    for (int i = 0; i < 9; i++) begin
      int lt;
      int le;
      lt = 0;
      le = 0;
      for (int j = 0; j < 9; j++) begin
        if (vals[j] < vals[i]) lt++;
        if (vals[j] <= vals[i]) le++;
      end
      if (lt <= 4 && le >= 5) return vals[i];
    end
    return '0;
  endfunction

  task automatic push_expected(input logic m);
    exp_t e;
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) begin
        e.pix = ref_pix(r, c, m);
        e.row = CW'(r);
        e.col = CW'(c);
        exp_q.push_back(e);
      end
    end
  endtask

  // kind: 0 ramp, 1 impulse at (1,1) in 7s, 2 row r = 4*r, 3 random, 4 impulse at (0,0) in 2s
  task automatic fill(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       img[i] = BL'(i % 32);
        1:       img[i] = BL'(7);
        2:       img[i] = BL'((4 * (i / D)) % 32);
        4:       img[i] = BL'(2);
        default: img[i] = BL'($urandom);
      endcase
    end
    if (kind == 1) img[1*D + 1] = BL'(31);
    if (kind == 4) img[0] = BL'(31);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // out_ready pattern: 0 always, 1 toggle, 2 random
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: compare each transfer against the scoreboard; check stall hold
  initial begin
    logic                  prev_stall;
    logic [BL+2*CW-1:0]    prev_word;
    exp_t                  e;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_hold", {pixel_out, out_row, out_col}, prev_word);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0d at (%0d,%0d), expected no output",
                     pixel_out, out_row, out_col);
          end else begin
            e = exp_q.pop_front();
            check("pixel", pixel_out, e.pix);
            check("row", out_row, e.row);
            check("col", out_col, e.col);
          end
          out_total++;
          last_row = out_row;
          last_col = out_col;
        end
        if (frame_done) done_total++;
        prev_stall = out_valid && !out_ready;
        prev_word  = {pixel_out, out_row, out_col};
      end
    end
  end

  task automatic run_frame(input logic m, input int vpct, input int rmode, input int abort_at);
    int idx;
    int beats;
    int cyc;
    int out0;
    int done0;
    idx = 0;
    beats = 0;
    cyc = 0;
    rdy_mode = rmode;
    out0 = out_total;
    done0 = done_total;
    while (idx < NPIX && cyc < 5000) begin
      @(posedge clk);
      #1;
      mode = (idx == 0) ? m : 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 99) < vpct);
      for (int k = 0; k < P; k++) begin
        pixel_in[k*BL +: BL] = (idx + k < NPIX) ? img[idx + k] : BL'($urandom);
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        idx += P;
        beats++;
      end
      cyc++;
    end
    check("load_beats", beats, BEATS);
    push_expected(m);
    // junk beats and a flipped mode while filtering must be ignored
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    pixel_in = PW'($urandom);
    mode = !m;
    @(negedge clk);
    check("in_ready_drop", in_ready, 0);
    cyc = 0;
    while (!frame_done && cyc < 20000) begin
      if (abort_at >= 0 && (out_total - out0) >= abort_at) break;
      @(posedge clk);
      #1;
      pixel_in = PW'($urandom);
      @(negedge clk);
      cyc++;
    end
    if (abort_at >= 0) begin
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      in_valid = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_pixel_out", pixel_out, 0);
      check("abort_out_row", out_row, 0);
      check("abort_out_col", out_col, 0);
      check("abort_frame_done", frame_done, 0);
      exp_q.delete();
      @(negedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
    end else begin
      check("frame_done_seen", frame_done, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      check("in_ready_reload", in_ready, 1);
      check("frame_done_pulses", done_total - done0, 1);
      check("frame_outputs", out_total - out0, NPIX);
      check("last_row", last_row, D - 1);
      check("last_col", last_col, D - 1);
      check("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    in_valid = 1'b0;
    mode     = 1'b0;
    pixel_in = '0;
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_pixel_out", pixel_out, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    check("rst_frame_done", frame_done, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    fill(0); run_frame(1'b1, 100, 0, -1);  // ramp pass-through, continuous
    fill(1); run_frame(1'b0, 100, 0, -1);  // impulse removed
    fill(2); run_frame(1'b0, 70, 1, -1);   // constant rows, toggling ready
    fill(0); run_frame(1'b0, 60, 2, -1);   // ramp median, random stalls
    fill(3); run_frame(1'b0, 80, 2, 5);    // reset at output 5
    run_frame(1'b0, 100, 0, -1);           // full frame after abort
    fill(4); run_frame(1'b0, 100, 0, -1);  // corner impulse
    fill(3); run_frame(1'b1, 50, 2, -1);
    fill(3); run_frame(1'b0, 90, 2, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
